// File: rtl/deserializer.sv
// Serial-to-parallel word receiver, MSB first, with valid/ack handoff.
// Flags framing aborts and overwritten unacknowledged words.
module deserializer #(
    parameter int WIDTH = 12
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             data_in,
    input  logic             send,
    input  logic             ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             last;

    assign last = (cnt == LAST);

    always_ff @(posedge CLK) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // a completing word below re-asserts data_valid
            if (ack && data_valid)
                data_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (send) begin
                        shreg <= {{(WIDTH-1){1'b0}}, data_in};
                        cnt   <= CW'(1);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    unique case (1'b1)
                        send && !last: begin
                            shreg <= {shreg[WIDTH-2:0], data_in};
                            cnt   <= cnt + CW'(1);
                            busy  <= 1'b1;
                        end
                        send && last: begin
                            data_out   <= {shreg[WIDTH-2:0], data_in};
                            data_valid <= 1'b1;
                            if (data_valid && !ack)
                                overrun <= 1'b1;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end
                        !send: begin
                            if (cnt != '0)
                                frame_err <= 1'b1;
                            cnt   <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule
